fir_tap_delay_line: RTL and testbench
=====================================

// Module: fir_tap_delay_line
// PURPOSE
//   Parametrised tapped delay line feeding the pipelined FIR multiply/add stages.
//   Holds the last DEPTH accepted samples of WIDTH bits and exposes every tap in parallel.
//   Adds global stall, synchronous flush, and per-tap valid tracking.
//   Reports fill level, so downstream accumulators ignore taps not yet loaded.
// PARAMETERS
//   WIDTH       13  sample width in bits (>=1); data is passed through unmodified, no sign handling
//   DEPTH       8   number of taps (>=2)
//   SHIFT_MODE  0   0: shift only on accepted in_valid (bubbles dropped)
//                   1: shift every non-stalled cycle (bubbles kept as zero/invalid taps)
//   CW          $clog2(DEPTH+1)  width of fill_cnt (derived, not overridden)
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous reset, active-low
//   stall      in   1            1 = freeze all state this cycle
//   flush      in   1            1 = clear all taps and valids at next edge
//   in_valid   in   1            din is a valid sample this cycle
//   din        in   WIDTH        input sample
//   taps       out  DEPTH*WIDTH  tap k at [k*WIDTH +: WIDTH]; tap0 = newest sample
//   tap_valid  out  DEPTH        bit k = tap k holds a real sample
//   dout       out  WIDTH        tap DEPTH-1 (oldest sample)
//   dout_valid out  1            tap_valid[DEPTH-1]
//   primed     out  1            all DEPTH tap_valid bits set
//   fill_cnt   out  CW           popcount of tap_valid, 0..DEPTH
// BEHAVIOUR
//   - All state changes on the rising clk edge; all outputs are registered or direct decodes of registers.
//   - Reset (rst==0 at edge): taps, tap_valid, fill_cnt cleared to 0; dout, dout_valid, primed read 0.
//   - Per-edge priority: reset > flush > stall > shift.
//   - Flush: same result as reset. It wins over stall and in_valid in the same cycle. The sample on din is discarded.
//   - Stall (flush=0): taps, tap_valid and fill_cnt hold; din is not captured, whatever the value of in_valid.
//   - Shift, SHIFT_MODE=0:
//       on in_valid=1 & !stall, tap[k] <= tap[k-1] for k=1..DEPTH-1, tap0 <= din, tap_valid shifts in 1.
//       When in_valid=0, everything holds.
//   - Shift, SHIFT_MODE=1:
//       every !stall cycle, tap[k] <= tap[k-1].
//       tap0 <= in_valid ? din : 0; tap_valid shifts in in_valid.
//   - Latency:
//       an accepted sample appears on tap0 one edge after acceptance.
//       It reaches dout after DEPTH shift edges (= DEPTH accepted samples in mode 0).
//   - Samples fall off the oldest tap on each shift. No overflow flag; this is a window, not a FIFO.
//   - fill_cnt:
//       mode 0: increments per accepted sample, saturates at DEPTH, then stays at DEPTH.
//       mode 1: equals the number of valid taps, so it may decrease as bubbles pass through.
//   - primed is set exactly when fill_cnt == DEPTH.
//   - Reset or flush mid-stream always restarts fill from 0. The first later sample lands on tap0 with fill_cnt=1.
//   - No combinational path from din to any output.
// TESTING
//   1 Reset: rst=0 for 2 cycles with in_valid=1, din=13'h0ABC
//     -> taps=0, tap_valid=0, fill_cnt=0, primed=0.
//   2 Fill (mode 0, DEPTH=8): feed 1..8 back-to-back
//     -> after 8th edge: primed=1, fill_cnt=8, tap0=8, dout=1.
//     Then feed 9 -> dout=2, fill_cnt stays 8.
//   3 Stall: primed line, stall=1 with in_valid=1, din=5 for 3 cycles
//     -> taps unchanged.
//     Release -> tap0=5 one edge later.
//   4 Bubbles (mode 1): A=3, bubble, B=7 on consecutive cycles
//     -> tap0=7, tap1=0 with valid 0, tap2=3, tap_valid[2:0]=3'b101, fill_cnt=2.
//     Mode 0, same stimulus -> tap0=7, tap1=3, fill_cnt=2.
//   5 Flush priority: primed line, flush=1 with stall=1, in_valid=1, din=9
//     -> next edge: all taps 0, fill_cnt=0, primed=0.
//   6 Reset mid-run + full-scale data: reset when primed, then feed 13'h1FFF
//     -> tap0=13'h1FFF, fill_cnt=1.
//     After 8 samples, dout=13'h1FFF, bit-exact.

Source files
------------

// File: rtl/fir_tap_delay_line.sv
// Tapped delay line for a pipelined FIR: holds the last DEPTH samples, exposes all taps
// in parallel with per-tap valid bits, fill level, stall and synchronous flush.
module fir_tap_delay_line #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SHIFT_MODE = 0,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         din,
  output logic [DEPTH*WIDTH-1:0]   taps,
  output logic [DEPTH-1:0]         tap_valid,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     primed,
  output logic [CW-1:0]            fill_cnt
);

  logic [WIDTH-1:0] tap_q [DEPTH];
  logic [WIDTH-1:0] tap_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             shift_en;

  // Next-state: flush beats stall, stall beats shift; fill is the popcount of the valid bits.
  always_comb begin
    tap_d    = tap_q;
    valid_d  = valid_q;
    fill_d   = fill_q;
    shift_en = (SHIFT_MODE != 0) ? 1'b1 : in_valid;
    if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) tap_d[k] = '0;
      valid_d = '0;
      fill_d  = '0;
    end else if (!stall && shift_en) begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) tap_d[k] = tap_q[k-1];
      tap_d[0] = in_valid ? din : '0;
      valid_d  = {valid_q[DEPTH-2:0], in_valid};
      fill_d   = '0;
      for (int k = 0; k < int'(DEPTH); k++) fill_d = fill_d + CW'(valid_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) tap_q[k] <= '0;
      valid_q <= '0;
      fill_q  <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) tap_q[k] <= tap_d[k];
      valid_q <= valid_d;
      fill_q  <= fill_d;
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = tap_q[g];
  end

  assign tap_valid  = valid_q;
  assign dout       = tap_q[DEPTH-1];
  assign dout_valid = valid_q[DEPTH-1];
  assign primed     = (fill_q == CW'(DEPTH));
  assign fill_cnt   = fill_q;

endmodule

// File: tb/tb_fir_tap_delay_line.sv
// Directed bench for fir_tap_delay_line: one instance per shift mode on shared stimulus.
module tb_fir_tap_delay_line;

  localparam int unsigned W  = 13;
  localparam int unsigned D  = 8;
  localparam int unsigned CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst, stall, flush, in_valid;
  logic [W-1:0] din;

  logic [D*W-1:0] taps0, taps1;
  logic [D-1:0]   tv0, tv1;
  logic [W-1:0]   dout0, dout1;
  logic           dv0, dv1, pr0, pr1;
  logic [CW-1:0]  fc0, fc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_tap_delay_line #(.WIDTH(W), .DEPTH(D), .SHIFT_MODE(0)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .din(din),
    .taps(taps0), .tap_valid(tv0), .dout(dout0), .dout_valid(dv0), .primed(pr0), .fill_cnt(fc0));

  fir_tap_delay_line #(.WIDTH(W), .DEPTH(D), .SHIFT_MODE(1)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .din(din),
    .taps(taps1), .tap_valid(tv1), .dout(dout1), .dout_valid(dv1), .primed(pr1), .fill_cnt(fc1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [W-1:0] v);
    din = v; in_valid = 1'b1; tick();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; din = 13'h0ABC;

    // Reset held two cycles with a valid sample present
    tick(); tick();
    chk("rst_taps",   128'(taps0), 128'(0));
    chk("rst_valid",  128'(tv0),   128'(0));
    chk("rst_fill",   128'(fc0),   128'(0));
    chk("rst_primed", 128'(pr0),   128'(0));
    chk("rst_dout",   128'({dv0, dout0}), 128'(0));
    chk("rst_m1",     128'({taps1, fc1, pr1}), 128'(0));

    // Fill with 1..8
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) feed(W'(i));
    chk("fill_primed", 128'(pr0),  128'(1));
    chk("fill_cnt",    128'(fc0),  128'(8));
    chk("fill_tap0",   128'(taps0[W-1:0]), 128'(8));
    chk("fill_dout",   128'(dout0), 128'(1));
    chk("fill_taps",   128'(taps0),
        128'({13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'd7, 13'd8}));
    chk("fill_valid",  128'(tv0),  128'(8'hFF));
    chk("fill_m1_cnt", 128'(fc1),  128'(8));
    feed(13'd9);
    chk("ninth_dout", 128'(dout0), 128'(2));
    chk("ninth_cnt",  128'(fc0),   128'(8));

    // Stall with a valid sample for three cycles
    stall = 1'b1; din = 13'd5; in_valid = 1'b1;
    tick(); tick(); tick();
    chk("stall_taps", 128'(taps0),
        128'({13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'd7, 13'd8, 13'd9}));
    chk("stall_cnt",  128'(fc0), 128'(8));
    chk("stall_m1",   128'(taps1[W-1:0]), 128'(9));
    stall = 1'b0;
    tick();
    chk("unstall_tap0", 128'(taps0[W-1:0]), 128'(5));
    chk("unstall_dout", 128'(dout0), 128'(3));
    in_valid = 1'b0; din = 13'h123;
    tick();
    chk("idle_m0_hold", 128'(taps0[W-1:0]), 128'(5));
    chk("idle_m1_bub",  128'({tv1[0], taps1[W-1:0]}), 128'(0));
    chk("idle_m1_cnt",  128'(fc1), 128'(7));

    // Bubble handling: A=3, bubble, B=7 from an empty line
    rst = 1'b0; tick(); rst = 1'b1;
    feed(13'd3);
    din = 13'h55; in_valid = 1'b0; tick();
    feed(13'd7);
    in_valid = 1'b0; stall = 1'b1;
    chk("bub_m1_taps", 128'(taps1[3*W-1:0]), 128'({13'd3, 13'd0, 13'd7}));
    chk("bub_m1_valid", 128'(tv1), 128'(8'b0000_0101));
    chk("bub_m1_cnt",  128'(fc1), 128'(2));
    chk("bub_m0_taps", 128'(taps0[2*W-1:0]), 128'({13'd3, 13'd7}));
    chk("bub_m0_valid", 128'(tv0), 128'(8'b0000_0011));
    chk("bub_m0_cnt",  128'(fc0), 128'(2));
    stall = 1'b0;

    // Flush wins over stall and in_valid
    for (int i = 10; i < 18; i++) feed(W'(i));
    chk("pre_flush_primed", 128'(pr0), 128'(1));
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; din = 13'd9;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("flush_taps",   128'(taps0), 128'(0));
    chk("flush_valid",  128'(tv0),   128'(0));
    chk("flush_cnt",    128'(fc0),   128'(0));
    chk("flush_primed", 128'(pr0),   128'(0));
    chk("flush_m1",     128'({taps1, tv1, fc1}), 128'(0));
    feed(13'd4);
    chk("post_flush", 128'({taps0[W-1:0], fc0}), 128'({13'd4, 4'd1}));

    // Reset mid-run, then full-scale data
    for (int i = 0; i < 7; i++) feed(13'd20);
    chk("pre_rst_primed", 128'(pr0), 128'(1));
    rst = 1'b0; tick(); rst = 1'b1;
    feed(13'h1FFF);
    chk("fs_tap0", 128'(taps0[W-1:0]), 128'(13'h1FFF));
    chk("fs_cnt",  128'(fc0), 128'(1));
    chk("fs_dv",   128'(dv0), 128'(0));
    for (int i = 0; i < 7; i++) feed(13'h1FFF);
    in_valid = 1'b0;
    chk("fs_dout",   128'({dv0, dout0}), 128'({1'b1, 13'h1FFF}));
    chk("fs_primed", 128'({pr0, fc0}),   128'({1'b1, 4'd8}));
    chk("fs_m1",     128'({pr1, dout1}), 128'({1'b1, 13'h1FFF}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
